// File: rtl/span_pkg.sv
// Shared types, widths and defaults for the span_seq measurement sequencer.
package span_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        GATE    = 3'd2,
        CLOSE   = 3'd3,
        SETTLE  = 3'd4,
        CAPTURE = 3'd5,
        FAIL    = 3'd6
    } span_state_e;

    localparam int CNT_W           = 32;
    localparam int SETTLE_CYC_DEF  = 4;
    localparam int TIMEOUT_CYC_DEF = 50000000;

    // A zero gate length would never terminate the gate countdown, so it runs as one cycle.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
        logic [CNT_W-1:0] val;
        if (len == {CNT_W{1'b0}}) begin
            val = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            val = len;
        end
        return val;
    endfunction

endpackage

// File: rtl/span_sync.sv
// N-stage single-bit synchroniser into the clk_base domain; clears to 0 on reset.
module span_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] stage_r;

    // Shift chain; the last stage is the synchronised value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= {N{1'b0}};
        end else begin
            stage_r <= {stage_r[N-2:0], d};
        end
    end

    assign q = stage_r[N-1];

endmodule

// File: rtl/span_seq.sv
// Sequencer that gates the equal-precision interval counter for a programmed
// number of clk_base cycles and captures its settled counts.
module span_seq
    import span_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk_base,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic [CNT_W-1:0] gate_len,
    input  logic             is_count,
    input  logic [CNT_W-1:0] count_1_in,
    input  logic [CNT_W-1:0] count_2_in,
    input  logic             pin_r,
    output logic             clk_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] result_1,
    output logic [CNT_W-1:0] result_2,
    output logic             lead
);

    localparam int               TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]    TO_ONE   = TW'(1);
    localparam logic [TW-1:0]    TO_MAX   = {TW{1'b1}};
    localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'((SETTLE_CYC < 1) ? 1 : SETTLE_CYC);

    span_state_e      state_r;
    span_state_e      state_nx;
    logic             is_s;
    logic             pin_s;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] gate_cnt_r;
    logic [TW-1:0]    to_cnt_r;
    logic             accept_s;
    logic             to_hit_s;
    logic             clk_en_nx_s;
    logic             busy_nx_s;
    logic             done_nx_s;

    span_sync #(.N(SYNC_STAGES)) u_sync_is (
        .clk   (clk_base),
        .rst_n (rst_n),
        .d     (is_count),
        .q     (is_s)
    );

    span_sync #(.N(SYNC_STAGES)) u_sync_pin (
        .clk   (clk_base),
        .rst_n (rst_n),
        .d     (pin_r),
        .q     (pin_s)
    );

    // State register.
    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_nx = state_r;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nx = (start && !done) ? ARM : IDLE;
                ARM: begin
                    if (is_s) begin
                        state_nx = GATE;
                    end else if (to_hit_s) begin
                        state_nx = FAIL;
                    end else begin
                        state_nx = ARM;
                    end
                end
                GATE:    state_nx = (gate_cnt_r == 32'd1) ? CLOSE : GATE;
                CLOSE: begin
                    if (!is_s) begin
                        state_nx = SETTLE;
                    end else if (to_hit_s) begin
                        state_nx = FAIL;
                    end else begin
                        state_nx = CLOSE;
                    end
                end
                SETTLE:  state_nx = (gate_cnt_r == 32'd1) ? CAPTURE : SETTLE;
                CAPTURE: state_nx = cont ? ARM : IDLE;
                FAIL:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs track the state.
    always_comb begin
        clk_en_nx_s = (state_nx == ARM) || (state_nx == GATE);
        busy_nx_s   = (state_nx != IDLE);
        done_nx_s   = (state_r == CAPTURE) && !abort;
        accept_s    = (state_r == IDLE) && (state_nx == ARM);
        to_hit_s    = (to_cnt_r == TO_LAST);
    end

    // Registered control outputs; reset drops clk_en immediately.
    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            clk_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            clk_en <= clk_en_nx_s;
            busy   <= busy_nx_s;
            done   <= done_nx_s;
        end
    end

    // Gate countdown, reused as the settle countdown after the gate closes.
    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt_r <= 32'd0;
        end else if ((state_r == ARM) && (state_nx == GATE)) begin
            gate_cnt_r <= len_r;
        end else if ((state_r == CLOSE) && (state_nx == SETTLE)) begin
            gate_cnt_r <= SET_LOAD;
        end else if (((state_r == GATE) || (state_r == SETTLE)) && (gate_cnt_r != 32'd0)) begin
            gate_cnt_r <= gate_cnt_r - 32'd1;
        end else begin
            gate_cnt_r <= gate_cnt_r;
        end
    end

    // Saturating handshake timeout counter, restarted on every entry to ARM or CLOSE.
    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= {TW{1'b0}};
        end else if ((state_nx != state_r) && ((state_nx == ARM) || (state_nx == CLOSE))) begin
            to_cnt_r <= {TW{1'b0}};
        end else if (((state_r == ARM) || (state_r == CLOSE)) && (to_cnt_r != TO_MAX)) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Latched gate length, sticky timeout flag and captured results.
    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            len_r    <= 32'd0;
            timeout  <= 1'b0;
            result_1 <= 32'd0;
            result_2 <= 32'd0;
            lead     <= 1'b0;
        end else begin
            if (accept_s) begin
                len_r   <= clamp_len(gate_len);
                timeout <= 1'b0;
            end else if ((state_r == FAIL) && !abort) begin
                timeout <= 1'b1;
            end
            if (done_nx_s) begin
                result_1 <= count_1_in;
                result_2 <= count_2_in;
                lead     <= pin_s;
            end
        end
    end

endmodule

// File: tb/tb_span_seq.sv
// Randomised self-checking bench for span_seq against a cycle-budget model
// of one measurement and a stand-in for the interval counter.
`timescale 1ns/1ps
module tb_span_seq;

    localparam int TO_CYC = 100;
    localparam int SYNC   = 2;
    localparam int SETTLE = 4;
    // Cycles for a clk_en change to come back through is_count and the synchroniser.
    localparam int LAT    = SYNC + 1;

    logic        clk_base = 1'b0;
    logic        rst_n, start, cont, abort, is_count, pin_r;
    logic [31:0] gate_len, count_1_in, count_2_in;
    logic        clk_en, busy, done, timeout, lead;
    logic [31:0] result_1, result_2;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          stopped = 1'b0;
    logic [31:0] res1_m = 32'd0;
    logic [31:0] res2_m = 32'd0;
    logic        lead_m = 1'b0;

    span_seq #(.SYNC_STAGES(SYNC), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk_base   (clk_base),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .abort      (abort),
        .gate_len   (gate_len),
        .is_count   (is_count),
        .count_1_in (count_1_in),
        .count_2_in (count_2_in),
        .pin_r      (pin_r),
        .clk_en     (clk_en),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .result_1   (result_1),
        .result_2   (result_2),
        .lead       (lead)
    );

    always #5 clk_base = ~clk_base;

    // Interval counter stand-in: isCount follows clk_en on the test-clock edge.
    always @(negedge clk_base) is_count <= stopped ? 1'b0 : clk_en;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_len(input logic [31:0] g);
        return (g == 32'd0) ? 1 : int'(g);
    endfunction

    // ARM + GATE + CLOSE + SETTLE + CAPTURE
    function automatic int busy_len(input logic [31:0] g);
        return LAT + eff_len(g) + LAT + SETTLE + 1;
    endfunction

    function automatic int en_len(input logic [31:0] g);
        return LAT + eff_len(g);
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_en"},   64'(clk_en),   64'd0);
        chk({tag, "_busy"}, 64'(busy),     64'd0);
        chk({tag, "_done"}, 64'(done),     64'd0);
        chk({tag, "_tmo"},  64'(timeout),  64'd0);
        chk({tag, "_r1"},   64'(result_1), 64'd0);
        chk({tag, "_r2"},   64'(result_2), 64'd0);
        chk({tag, "_lead"}, 64'(lead),     64'd0);
    endtask

    task automatic run_single(input logic [31:0] g, input logic [31:0] c1, input logic [31:0] c2,
                              input logic p, input bit poke);
        int nb, ne, nd;
        count_1_in = c1; count_2_in = c2; pin_r = p; cont = 1'b0;
        gate_len = g; start = 1'b1;
        @(negedge clk_base);
        start = 1'b0;
        chk("tmo_clr", 64'(timeout), 64'd0);
        nb = 0; ne = 0; nd = 0;
        while (busy && nb < 5000) begin
            nb++; ne += int'(clk_en); nd += int'(done);
            if (poke && nb == busy_len(g) / 2) begin
                start = 1'b1; gate_len = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk_base);
        end
        start = 1'b0;
        res1_m = c1; res2_m = c2; lead_m = p;
        chk("busy_cyc", 64'(nb), 64'(busy_len(g)));
        chk("en_cyc",   64'(ne), 64'(en_len(g)));
        chk("done_mid", 64'(nd), 64'd0);
        chk("done",     64'(done), 64'd1);
        chk("res1",     64'(result_1), 64'(res1_m));
        chk("res2",     64'(result_2), 64'(res2_m));
        chk("lead",     64'(lead), 64'(lead_m));
        start = 1'b1;
        @(negedge clk_base);
        start = 1'b0;
        chk("done_pulse", 64'(done), 64'd0);
        chk("start_at_done", 64'(busy), 64'd0);
        chk("tmo_keep", 64'(timeout), 64'd0);
    endtask

    task automatic run_timeout();
        int nb, ne, nd;
        stopped = 1'b1;
        gate_len = 32'd7; start = 1'b1;
        @(negedge clk_base);
        start = 1'b0;
        nb = 0; ne = 0; nd = 0;
        while (busy && nb < 5000) begin
            nb++; ne += int'(clk_en); nd += int'(done);
            @(negedge clk_base);
        end
        nd += int'(done);
        chk("to_busy", 64'(nb), 64'(TO_CYC + 1));
        chk("to_en",   64'(ne), 64'(TO_CYC));
        chk("to_done", 64'(nd), 64'd0);
        chk("to_flag", 64'(timeout), 64'd1);
        chk("to_r1",   64'(result_1), 64'(res1_m));
        chk("to_r2",   64'(result_2), 64'(res2_m));
        stopped = 1'b0;
        repeat (2) @(negedge clk_base);
        chk("to_sticky", 64'(timeout), 64'd1);
    endtask

    task automatic run_cont(input logic [31:0] g);
        int c1s[3] = '{10, 30, 50};
        int c2s[3] = '{20, 40, 60};
        int nb, ne, idx;
        logic p;
        p = 1'($urandom);
        pin_r = p; count_1_in = 32'(c1s[0]); count_2_in = 32'(c2s[0]);
        cont = 1'b1; gate_len = g; start = 1'b1;
        @(negedge clk_base);
        start = 1'b0;
        nb = 0; ne = 0; idx = 0;
        while (busy && nb < 5000) begin
            nb++; ne += int'(clk_en);
            if (done && idx < 2) begin
                chk("ct_r1", 64'(result_1), 64'(c1s[idx]));
                chk("ct_r2", 64'(result_2), 64'(c2s[idx]));
                idx++;
                count_1_in = 32'(c1s[idx]); count_2_in = 32'(c2s[idx]);
                if (idx == 2) cont = 1'b0;
            end
            @(negedge clk_base);
        end
        chk("ct_dones", 64'(idx), 64'd2);
        chk("ct_busy",  64'(nb), 64'(3 * busy_len(g)));
        chk("ct_en",    64'(ne), 64'(3 * en_len(g)));
        chk("ct_done3", 64'(done), 64'd1);
        chk("ct_r1_3",  64'(result_1), 64'd50);
        chk("ct_r2_3",  64'(result_2), 64'd60);
        chk("ct_lead",  64'(lead), 64'(p));
        res1_m = 32'd50; res2_m = 32'd60; lead_m = p;
        @(negedge clk_base);
        chk("ct_idle", 64'(busy), 64'd0);
    endtask

    task automatic run_abort();
        int nd;
        count_1_in = $urandom; count_2_in = $urandom;
        gate_len = 32'd50; start = 1'b1;
        @(negedge clk_base);
        start = 1'b0;
        repeat (LAT + 10) @(negedge clk_base);
        chk("ab_gating", 64'(clk_en), 64'd1);
        abort = 1'b1;
        @(negedge clk_base);
        abort = 1'b0;
        chk("ab_en",   64'(clk_en), 64'd0);
        chk("ab_busy", 64'(busy), 64'd0);
        nd = int'(done);
        repeat (8) begin
            @(negedge clk_base);
            nd += int'(done) + int'(busy);
        end
        chk("ab_quiet", 64'(nd), 64'd0);
        chk("ab_r1",    64'(result_1), 64'(res1_m));
        chk("ab_r2",    64'(result_2), 64'(res2_m));
        chk("ab_tmo",   64'(timeout), 64'd0);
    endtask

    task automatic run_reset_in_settle();
        count_1_in = $urandom; count_2_in = $urandom;
        gate_len = 32'd20; start = 1'b1;
        @(negedge clk_base);
        start = 1'b0;
        repeat (LAT + 20 + LAT + 1) @(negedge clk_base);
        chk("rs_busy", 64'(busy), 64'd1);
        chk("rs_en",   64'(clk_en), 64'd0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rs");
        res1_m = 32'd0; res2_m = 32'd0; lead_m = 1'b0;
        repeat (2) @(negedge clk_base);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_base);
        run_single(32'd15, 32'd1234, 32'd4321, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
        gate_len = 32'd0; count_1_in = 32'd0; count_2_in = 32'd0; pin_r = 1'b0;
        repeat (2) @(negedge clk_base);
        check_outputs_zero("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk_base);

        run_single(32'd1000, 32'd700, 32'd300, 1'b1, 1'b0);
        run_single(32'd0, 32'd55, 32'd66, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_single(32'($urandom_range(0, 60)), $urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        run_timeout();
        run_single(32'd3, 32'd11, 32'd22, 1'b1, 1'b0);
        run_cont(32'($urandom_range(1, 40)));
        run_abort();
        run_reset_in_settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
